// File: rtl/noc_pkg.sv
// Shared definitions for the NoC flit receiver: flit field layout, flit and
// receive-entry payload structs, FSM state encoding, and flit pack/unpack helpers.
package noc_pkg;

    localparam int unsigned FLIT_W   = 13;
    localparam int unsigned DEST_W   = 2;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ENTRY_W  = 13;

    localparam int unsigned DEST_MSB = 12;
    localparam int unsigned DEST_LSB = 11;
    localparam int unsigned TYPE_MSB = 10;
    localparam int unsigned TYPE_LSB = 9;
    localparam int unsigned PAY_MSB  = 8;
    localparam int unsigned PAY_LSB  = 1;
    localparam int unsigned EOP_BIT  = 0;

    typedef enum logic [1:0] {
        DATA = 2'b00,
        HEAD = 2'b01,
        CTRL = 2'b10,
        RSVD = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DROP  = 2'b10
    } rx_state_e;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        pkt_type_e         package_type;
        logic [DATA_W-1:0] payload;
        logic              eop;
    } packet_t;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
    } rx_entry_t;

    function automatic logic [FLIT_W-1:0] pack_flit(input packet_t p);
        logic [FLIT_W-1:0] f;
        f                    = '0;
        f[DEST_MSB:DEST_LSB] = p.dest;
        f[TYPE_MSB:TYPE_LSB] = p.package_type;
        f[PAY_MSB:PAY_LSB]   = p.payload;
        f[EOP_BIT]           = p.eop;
        return f;
    endfunction

    function automatic packet_t unpack_flit(input logic [FLIT_W-1:0] f);
        packet_t p;
        p.dest         = f[DEST_MSB:DEST_LSB];
        p.package_type = pkt_type_e'(f[TYPE_MSB:TYPE_LSB]);
        p.payload      = f[PAY_MSB:PAY_LSB];
        p.eop          = f[EOP_BIT];
        return p;
    endfunction

endpackage

// File: rtl/noc_flit_receiver_if.sv
// Flit input link and byte output stream of the receiver.
// master: flit source / byte sink side; slave: the receiver itself.
interface noc_flit_receiver_if;
    import noc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_flit;
    logic              out_valid;
    logic              out_ready;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_err;

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_dest, out_data, out_sop, out_eop, out_err
    );

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_dest, out_data, out_sop, out_eop, out_err
    );

endinterface

// File: rtl/noc_rx_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Ports: clk, reset_n (async active-low), push/push_data, pop/pop_data (head), full, empty.
// Flags are computed from the next occupancy, so pop has no combinational path to full.
module noc_rx_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/noc_flit_receiver.sv
// NoC flit receiver: decodes flits, enforces message framing and node filtering,
// and buffers accepted bytes into a sop/eop/err-marked byte stream.
// Ports: clk, reset_n (async active-low), bus (flit in / byte out, slave side),
// ctrl_valid/ctrl_data (control flit side channel), msg_count, err_count.
module noc_flit_receiver
    import noc_pkg::*;
#(
    parameter logic [1:0]  NODE_ID    = 2'b01,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_LEN    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    noc_flit_receiver_if.slave  bus,
    output logic                ctrl_valid,
    output logic [DATA_W-1:0]   ctrl_data,
    output logic [15:0]         msg_count,
    output logic [7:0]          err_count
);

    localparam int unsigned BEAT_W = $clog2(MAX_LEN + 1);

    rx_state_e       state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    packet_t         pkt;
    rx_entry_t       push_entry;
    rx_entry_t       head;
    logic            accept;
    logic            dest_hit;
    logic            push;
    logic            msg_inc;
    logic            err_inc;
    logic            ctrl_hit;
    logic            fifo_full;
    logic            fifo_empty;

    assign bus.in_ready = ~fifo_full;
    assign accept       = bus.in_valid & ~fifo_full;
    assign pkt          = unpack_flit(bus.in_flit);
    assign dest_hit     = (pkt.dest == NODE_ID);

    // Flit decode: next state, FIFO push and counter events
    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        push       = 1'b0;
        push_entry = '0;
        msg_inc    = 1'b0;
        err_inc    = 1'b0;
        ctrl_hit   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!dest_hit) begin
                        if (!pkt.eop) state_nxt = DROP;
                    end else begin
                        case (pkt.package_type)
                            DATA, HEAD: begin
                                push            = 1'b1;
                                push_entry.dest = pkt.dest;
                                push_entry.data = pkt.payload;
                                push_entry.sop  = 1'b1;
                                if (pkt.eop) begin
                                    push_entry.eop = 1'b1;
                                    msg_inc        = 1'b1;
                                end else if (pkt.package_type == HEAD) begin
                                    beat_nxt  = BEAT_W'(1);
                                    state_nxt = BURST;
                                end else begin
                                    // Unterminated lone DATA flit closes itself as an error
                                    push_entry.eop = 1'b1;
                                    push_entry.err = 1'b1;
                                    err_inc        = 1'b1;
                                    state_nxt      = DROP;
                                end
                            end
                            CTRL: begin
                                if (pkt.eop) begin
                                    ctrl_hit = 1'b1;
                                end else begin
                                    err_inc   = 1'b1;
                                    state_nxt = DROP;
                                end
                            end
                            default: begin
                                err_inc = 1'b1;
                                if (!pkt.eop) state_nxt = DROP;
                            end
                        endcase
                    end
                end
                BURST: begin
                    push = 1'b1;
                    // Last legal beat must carry eop, otherwise the message is too long
                    if (dest_hit && pkt.package_type == DATA &&
                        (beat < BEAT_W'(MAX_LEN - 1) || pkt.eop)) begin
                        push_entry.dest = pkt.dest;
                        push_entry.data = pkt.payload;
                        push_entry.eop  = pkt.eop;
                        beat_nxt        = beat + BEAT_W'(1);
                        if (pkt.eop) begin
                            msg_inc   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        push_entry.dest = NODE_ID;
                        push_entry.eop  = 1'b1;
                        push_entry.err  = 1'b1;
                        err_inc         = 1'b1;
                        state_nxt       = pkt.eop ? IDLE : DROP;
                    end
                end
                DROP: begin
                    if (pkt.eop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, beat counter, control side register and status counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= '0;
            ctrl_valid <= 1'b0;
            ctrl_data  <= '0;
            msg_count  <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            ctrl_valid <= ctrl_hit;
            if (ctrl_hit) ctrl_data <= pkt.payload;
            msg_count  <= msg_count + 16'(msg_inc);
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    noc_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (bus.out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head entry onto the output stream, zeroed while empty
    always_comb begin
        bus.out_valid = ~fifo_empty;
        bus.out_dest  = '0;
        bus.out_data  = '0;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.out_err   = 1'b0;
        if (!fifo_empty) begin
            bus.out_dest = head.dest;
            bus.out_data = head.data;
            bus.out_sop  = head.sop;
            bus.out_eop  = head.eop;
            bus.out_err  = head.err;
        end
    end

endmodule

// File: tb/tb_noc_flit_receiver.sv
// Self-checking bench for noc_flit_receiver: directed cases plus random frames
// checked against a message-level reference model and output scoreboard.
module tb_noc_flit_receiver;
    import noc_pkg::*;

    localparam logic [1:0] NODE  = 2'b01;
    localparam int         DEPTH = 4;
    localparam int         MAXL  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_valid;
    logic [7:0]  ctrl_data;
    logic [15:0] msg_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    noc_flit_receiver_if bif();

    noc_flit_receiver #(
        .NODE_ID    (NODE),
        .FIFO_DEPTH (DEPTH),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bif),
        .ctrl_valid (ctrl_valid),
        .ctrl_data  (ctrl_data),
        .msg_count  (msg_count),
        .err_count  (err_count)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [12:0] exp_q[$];
    logic [12:0] frame_q[$];
    int          m_msg = 0;
    int          m_err = 0;
    int          m_ctrl = 0;
    logic [7:0]  m_ctrl_data = 8'h00;
    int          ctrl_pulses = 0;
    int          n_acc = 0;
    int          ready_mode = 0;
    logic        bp_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [1:0] d, input logic [1:0] t,
                                       input logic [7:0] p, input logic e);
        return {d, t, p, e};
    endfunction

    function automatic logic [12:0] ent(input logic [1:0] d, input logic [7:0] p,
                                        input logic s, input logic e, input logic r);
        return {d, p, s, e, r};
    endfunction

    // Message-level model: one frame is every flit up to and including eop
    task automatic model_frame();
        int          len;
        logic [12:0] f;
        len = frame_q.size();
        f   = frame_q[0];
        if (f[12:11] != NODE) return;
        case (f[10:9])
            2'b00, 2'b01: begin
                if (len == 1) begin
                    exp_q.push_back(ent(NODE, f[8:1], 1'b1, 1'b1, 1'b0));
                    m_msg++;
                end else if (f[10:9] == 2'b00) begin
                    exp_q.push_back(ent(NODE, f[8:1], 1'b1, 1'b1, 1'b1));
                    m_err++;
                end else begin
                    exp_q.push_back(ent(NODE, f[8:1], 1'b1, 1'b0, 1'b0));
                    for (int i = 1; i < len; i++) begin
                        logic last;
                        f    = frame_q[i];
                        last = (i == len - 1);
                        if (f[12:11] == NODE && f[10:9] == 2'b00 && (i < MAXL - 1 || last)) begin
                            exp_q.push_back(ent(NODE, f[8:1], 1'b0, last, 1'b0));
                            if (last) m_msg++;
                        end else begin
                            exp_q.push_back(ent(NODE, 8'h00, 1'b0, 1'b1, 1'b1));
                            m_err++;
                            break;
                        end
                    end
                end
            end
            2'b10: begin
                if (len == 1) begin
                    m_ctrl++;
                    m_ctrl_data = f[8:1];
                end else begin
                    m_err++;
                end
            end
            default: m_err++;
        endcase
    endtask

    task automatic send(input logic [12:0] f);
        int t;
        t = 0;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_flit  = f;
        while (!bif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 32'(t), 32'(0));
        @(posedge clk);
        n_acc++;
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic run_frame();
        model_frame();
        foreach (frame_q[i]) send(frame_q[i]);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_msg"}, 32'(msg_count), 32'(m_msg & 32'hFFFF));
        check({tag, "_err"}, 32'(err_count), 32'((m_err > 255) ? 255 : m_err));
        check({tag, "_ctrl_pulses"}, 32'(ctrl_pulses), 32'(m_ctrl));
        check({tag, "_ctrl_data"}, 32'(ctrl_data), 32'(m_ctrl_data));
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        repeat (3) @(negedge clk);
        while ((exp_q.size() != 0 || bif.out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        #2;
        check({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
        check_counters(tag);
    endtask

    // Output sink: random/forced out_ready, scoreboard on each pop
    initial begin
        logic [12:0] got;
        logic [12:0] exp;
        bif.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bif.out_ready = 1'b0;
                1:       bif.out_ready = 1'b1;
                default: bif.out_ready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (reset_n && bif.out_valid && bif.out_ready) begin
                got = {bif.out_dest, bif.out_data, bif.out_sop, bif.out_eop, bif.out_err};
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_entry", 32'(got), 32'(exp));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ctrl_valid) ctrl_pulses++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc0;
        int t;
        bif.in_valid = 1'b0;
        bif.in_flit  = '0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bif.out_valid), 32'(0));
        check("rst_out_fields", 32'({bif.out_dest, bif.out_data, bif.out_sop, bif.out_eop, bif.out_err}), 32'(0));
        check("rst_counters", 32'({msg_count, err_count}), 32'(0));
        check("rst_ctrl", 32'({ctrl_valid, ctrl_data}), 32'(0));
        check("rst_in_ready", 32'(bif.in_ready), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;

        // Single DATA flit: visible at the head one cycle after accept
        ready_mode = 1;
        frame_q = {mk(NODE, DATA, 8'hA5, 1'b1)};
        run_frame();
        check("single_valid", 32'(bif.out_valid), 32'(1));
        check("single_entry", 32'({bif.out_data, bif.out_sop, bif.out_eop, bif.out_err}), 32'({8'hA5, 3'b110}));
        check("single_msg", 32'(msg_count), 32'(1));
        wait_drain("single");

        // Three-beat burst
        frame_q = {mk(NODE, HEAD, 8'h5A, 1'b0), mk(NODE, DATA, 8'hFF, 1'b0), mk(NODE, DATA, 8'h00, 1'b1)};
        run_frame();
        wait_drain("burst3");

        // Burst broken by a foreign-dest flit
        frame_q = {mk(NODE, HEAD, 8'h11, 1'b0), mk(2'b10, DATA, 8'h22, 1'b1)};
        run_frame();
        wait_drain("burst_break");

        // Control, reserved and foreign flits push nothing
        frame_q = {mk(NODE, CTRL, 8'hAA, 1'b1)};
        run_frame();
        frame_q = {mk(NODE, RSVD, 8'h55, 1'b1)};
        run_frame();
        frame_q = {mk(2'b00, DATA, 8'h77, 1'b1)};
        run_frame();
        wait_drain("ctrl_rsvd");

        // Back-pressure: FIFO fills after DEPTH accepts
        ready_mode = 0;
        repeat (2) @(negedge clk);
        acc0    = n_acc;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    frame_q = {mk(NODE, DATA, 8'(8'h30 + i), 1'b1)};
                    run_frame();
                end
                bp_done = 1'b1;
            end
        join_none
        repeat (12) @(negedge clk);
        #2;
        check("bp_accepts", 32'(n_acc - acc0), 32'(DEPTH));
        check("bp_in_ready", 32'(bif.in_ready), 32'(0));
        ready_mode = 1;
        t = 0;
        while (!bp_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("bp_done", 32'(bp_done), 32'(1));
        wait_drain("bp");
        check("empty_zero", 32'({bif.out_valid, bif.out_dest, bif.out_data, bif.out_sop, bif.out_eop, bif.out_err}), 32'(0));

        // Longest legal message, then one that overruns the length limit
        frame_q = {mk(NODE, HEAD, 8'h80, 1'b0)};
        for (int i = 1; i < MAXL; i++) frame_q.push_back(mk(NODE, DATA, 8'(8'h80 + i), i == MAXL - 1));
        run_frame();
        frame_q = {mk(NODE, HEAD, 8'hC0, 1'b0)};
        for (int i = 1; i <= MAXL; i++) frame_q.push_back(mk(NODE, DATA, 8'(8'hC0 + i), 1'b0));
        frame_q.push_back(mk(NODE, DATA, 8'hCF, 1'b1));
        run_frame();
        wait_drain("maxlen");

        // Reset mid-burst discards buffered bytes and counters
        ready_mode = 0;
        repeat (2) @(negedge clk);
        send(mk(NODE, HEAD, 8'h21, 1'b0));
        send(mk(NODE, DATA, 8'h22, 1'b0));
        send(mk(NODE, DATA, 8'h23, 1'b0));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'({bif.out_valid, bif.out_dest, bif.out_data, bif.out_sop, bif.out_eop, bif.out_err}), 32'(0));
        check("midrst_counters", 32'({msg_count, err_count, ctrl_valid, ctrl_data}), 32'(0));
        exp_q.delete();
        m_msg = 0;
        m_err = 0;
        m_ctrl_data = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        ready_mode = 1;
        frame_q = {mk(NODE, DATA, 8'h3C, 1'b1)};
        run_frame();
        wait_drain("post_rst");

        // err_count saturation
        for (int i = 0; i < 260; i++) begin
            frame_q = {mk(NODE, RSVD, 8'($urandom), 1'b1)};
            run_frame();
        end
        wait_drain("err_sat");

        // Random frames with random back-pressure
        ready_mode = 2;
        for (int n = 0; n < 150; n++) begin
            int len;
            len = $urandom_range(1, 10);
            frame_q.delete();
            for (int i = 0; i < len; i++) begin
                logic [1:0] d;
                logic [1:0] ty;
                d = ($urandom_range(0, 9) == 0) ? 2'($urandom) : NODE;
                if (i == 0) ty = ($urandom_range(0, 1) == 0) ? 2'(HEAD) : 2'($urandom);
                else        ty = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'(DATA);
                frame_q.push_back(mk(d, ty, 8'($urandom), i == len - 1));
            end
            run_frame();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_mode = 1;
        wait_drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_flit_receiver.md
Name: noc_flit_receiver

Overview:
Receiving end of the NoC flit link. It accepts packed 13-bit flits over a valid/ready handshake and decodes them into dest, type, payload and eop. It enforces message framing and filters by node address, then buffers accepted bytes in a small FIFO that drives a byte stream with sop/eop/err markers. Control flits are diverted to a side register, and status counters are exported for the scoreboard and monitor.

Parameters:
NODE_ID, 2'b01, destination address owned by this receiver
FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2
MAX_LEN, 8, maximum flits per message, head included

Ports:
clk  input  1  clock
reset_n  input  1  reset
in_valid  input  1  flit valid
in_ready  output  1  flit accept; 1 when the FIFO is not full
in_flit  input  13  {dest[12:11], type[10:9], payload[8:1], eop[0]}
out_valid  output  1  FIFO not empty
out_ready  input  1  downstream accept
out_dest  output  2  dest of the head entry
out_data  output  8  payload byte
out_sop  output  1  first byte of a message
out_eop  output  1  last byte of a message
out_err  output  1  message terminated by a protocol violation
ctrl_valid  output  1  one-cycle pulse, control flit received
ctrl_data  output  8  last control payload, held
msg_count  output  16  good messages delivered, wraps at 16'hFFFF
err_count  output  8  violations, saturates at 8'hFF

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Reset clears FIFO pointers, state to IDLE, and all outputs/counters to 0. Assertion mid-message discards everything, including FIFO contents.
- Accept condition: in_valid & in_ready. in_ready = !fifo_full and has no combinational path from out_ready. When full, no push occurs even if a pop happens that cycle.
- Latency: an accepted flit is visible at the FIFO head the following cycle. Pop condition: out_valid & out_ready. Push and pop may happen in the same cycle when the FIFO is not full.
- Types: 00 DATA, 01 HEAD (burst start), 10 CTRL, 11 RESERVED.
- FSM states: IDLE, BURST, DROP. A beat counter tracks flits in the current message.
- IDLE transitions:
  - dest != NODE_ID: flit is consumed and not pushed. eop=0 goes to DROP; otherwise stay in IDLE. No error is counted.
  - DATA with eop=1: push {sop=1, eop=1, err=0}; msg_count+1.
  - DATA with eop=0: treated as a violation. Push {sop=1, eop=1, err=1, data=payload}; err_count+1; go to DROP.
  - HEAD with eop=0: push {sop=1, eop=0}; beat=1; go to BURST.
  - HEAD with eop=1: single-beat burst, handled the same as DATA with eop=1.
  - CTRL with eop=1: ctrl_data <= payload and ctrl_valid pulses next cycle. Nothing is pushed.
  - CTRL with eop=0: err_count+1; go to DROP.
  - RESERVED: err_count+1. eop=1 stays in IDLE; eop=0 goes to DROP. Nothing is pushed.
- BURST transitions:
  - DATA with matching dest and beat < MAX_LEN-1: push {sop=0, eop=in_eop}; beat+1. On eop, msg_count+1 and go to IDLE.
  - Any other type, dest mismatch, or beat == MAX_LEN-1 with eop=0:
    - Push a terminator {sop=0, eop=1, err=1, data=8'h00, dest=burst dest}.
    - err_count+1.
    - Go to IDLE if the violating flit has eop=1, otherwise DROP.
- DROP: consume flits without pushing; go to IDLE on the flit with eop=1.
- The FIFO holds 13 bits per entry: {dest, data, sop, eop, err}. The out_* signals reflect the head entry and are 0 when empty.
- err_count holds at 8'hFF. msg_count wraps to 0.

Decomposition:
- noc_pkg holds:
  - FLIT_W=13 and the field bit positions
  - typedef enum pkt_type_e {DATA, HEAD, CTRL, RSVD}
  - packet_t {dest, package_type, payload, eop}
  - rx_entry_t
  - functions pack_flit() and unpack_flit()
- Sub-module noc_rx_fifo: synchronous FIFO parameterised on width and depth. It has registered full/empty flags, an async active-low reset, and no combinational path from pop to full.

Test Plan:
- Single DATA flit {dest=01, DATA, A5, eop=1} with out_ready=1 -> one cycle later out_valid=1, data=A5, sop=1, eop=1, err=0; msg_count=1.
- Burst HEAD 5A (eop=0), DATA FF (eop=0), DATA 00 (eop=1), all dest=01 -> bytes 5A/FF/00 with sop only on 5A and eop only on 00; msg_count+1.
- Burst HEAD 11, then a flit {dest=10, DATA, 22, eop=1} -> output 11 (sop=1), then 00 (eop=1, err=1); err_count=1; state returns to IDLE.
- CTRL AA eop=1, then RESERVED 55 eop=1, then dest=00 DATA 77 -> ctrl_valid pulses once with ctrl_data=AA; err_count+1; nothing is pushed for any of the three flits.
- out_ready=0 while sending 5 single flits at FIFO_DEPTH=4 -> in_ready drops after 4 accepts; the 5th is held until out_ready=1; all 5 are delivered in order.
- HEAD followed by 8 DATA eop=0 at MAX_LEN=8 -> the 8th flit produces the err terminator and the rest drop until eop; reset_n pulsed mid-burst -> all outputs 0, the next single flit is delivered normally.
